// File: rtl/lincomb_pkg.sv
// ============================================================================
// lincomb_pkg : shared widths, latency helper and types for lincomb_pipe
// Rev 1.0
// ============================================================================
`default_nettype none

package lincomb_pkg;

  localparam int DEF_N_TERMS = 4;
  localparam int DEF_IN_W    = 8;
  localparam int DEF_COEF_W  = 5;
  localparam int DEF_ACC_W   = 20;
  localparam int DEF_OUT_W   = 16;

  // Config address that selects the bias register (one past the last coefficient)
  localparam int BIAS_ADDR = DEF_N_TERMS;

  typedef logic signed [DEF_COEF_W-1:0]         coef_t;
  typedef logic signed [DEF_IN_W+DEF_COEF_W:0]  prod_t;
  typedef logic signed [DEF_ACC_W-1:0]          acc_t;

  // Register stages: product capture plus one per adder-tree level
  function automatic int lincomb_lat(input int n_terms);
    return 1 + $clog2(n_terms + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/lincomb_add_stage.sv
// ============================================================================
// lincomb_add_stage : one registered adder-tree level, pairs N_IN sums down to N_IN/2
// Rev 1.0
// ============================================================================
`default_nettype none

module lincomb_add_stage
  import lincomb_pkg::*;
#(
  parameter int N_IN  = 2,
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      advance,
  input  logic                      in_valid,
  input  logic [N_IN*ACC_W-1:0]     in_sum,
  output logic                      out_valid,
  output logic [(N_IN/2)*ACC_W-1:0] out_sum
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
    end else if (advance) begin
      out_valid <= in_valid;
      for (int j = 0; j < N_IN/2; j++) begin
        out_sum[j*ACC_W +: ACC_W] <= in_sum[(2*j)*ACC_W +: ACC_W] + in_sum[(2*j+1)*ACC_W +: ACC_W];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/lincomb_pipe.sv
// ============================================================================
// lincomb_pipe : pipelined E = sum(k_i*X_i) + BIAS with valid/ready back-pressure.
// Optional LINCOMB_SAT_EN clamps out_data on overflow instead of wrapping.
// Rev 1.0
// ============================================================================
`default_nettype none

module lincomb_pipe
  import lincomb_pkg::*;
#(
  parameter int N_TERMS = DEF_N_TERMS,
  parameter int IN_W    = DEF_IN_W,
  parameter int COEF_W  = DEF_COEF_W,
  parameter int ACC_W   = DEF_ACC_W,
  parameter int OUT_W   = DEF_OUT_W
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [N_TERMS*IN_W-1:0]        in_data,
  input  logic                           cfg_we,
  input  logic [$clog2(N_TERMS+1)-1:0]   cfg_addr,
  input  logic [ACC_W-1:0]               cfg_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [OUT_W-1:0]               out_data,
  output logic                           out_ovf,
  output logic                           busy
);

  localparam int AW       = $clog2(N_TERMS + 1);
  localparam int LEVELS   = lincomb_lat(N_TERMS) - 1;
  localparam int LEAVES   = 1 << LEVELS;
  localparam int PROD_W   = IN_W + COEF_W + 1;
  localparam int BIAS_SEL = N_TERMS;

  // Bit offset of tree level l inside the flat bus (levels stored back to back)
  function automatic int lvl_off(input int l);
    return (2*LEAVES - 2*(LEAVES >> l)) * ACC_W;
  endfunction

  logic signed [COEF_W-1:0] coef [N_TERMS];
  logic signed [ACC_W-1:0]  bias;
  logic signed [PROD_W-1:0] prod [N_TERMS];
  logic signed [ACC_W-1:0]  leaf_q [N_TERMS+1];
  logic                     s1_valid;
  logic                     advance;
  logic signed [ACC_W-1:0]  sum;

  wire [(2*LEAVES-1)*ACC_W-1:0] tree;
  wire [LEVELS:0]               vld;

  assign advance   = ~out_valid | out_ready;
  assign in_ready  = advance;
  assign vld[0]    = s1_valid;
  assign out_valid = vld[LEVELS];
  assign busy      = |vld;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_TERMS; i++) coef[i] <= '0;
      bias <= '0;
    end else if (cfg_we) begin
      for (int i = 0; i < N_TERMS; i++) begin
        if (cfg_addr == AW'(i)) coef[i] <= cfg_data[COEF_W-1:0];
      end
      if (cfg_addr == AW'(BIAS_SEL)) bias <= cfg_data;
    end
  end

  for (genvar i = 0; i < N_TERMS; i++) begin : g_prod
    logic signed [PROD_W-1:0] x_ext;
    logic signed [PROD_W-1:0] k_ext;
    assign x_ext   = $signed(PROD_W'(in_data[i*IN_W +: IN_W]));
    assign k_ext   = PROD_W'(coef[i]);
    assign prod[i] = x_ext * k_ext;
  end

  // Coefficients and bias are frozen into the sample here, so later writes never touch it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      for (int i = 0; i <= N_TERMS; i++) leaf_q[i] <= '0;
    end else if (advance) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        for (int i = 0; i < N_TERMS; i++) leaf_q[i] <= ACC_W'(prod[i]);
        leaf_q[N_TERMS] <= bias;
      end
    end
  end

  for (genvar i = 0; i < LEAVES; i++) begin : g_leaf
    if (i <= N_TERMS) begin : g_real
      assign tree[i*ACC_W +: ACC_W] = leaf_q[i];
    end else begin : g_pad
      assign tree[i*ACC_W +: ACC_W] = '0;
    end
  end

  for (genvar l = 0; l < LEVELS; l++) begin : g_level
    localparam int OFF_IN  = lvl_off(l);
    localparam int OFF_OUT = lvl_off(l + 1);
    localparam int N_IN    = LEAVES >> l;
    lincomb_add_stage #(
      .N_IN  (N_IN),
      .ACC_W (ACC_W)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .advance   (advance),
      .in_valid  (vld[l]),
      .in_sum    (tree[OFF_IN +: N_IN*ACC_W]),
      .out_valid (vld[l+1]),
      .out_sum   (tree[OFF_OUT +: (N_IN/2)*ACC_W])
    );
  end

  assign sum = tree[lvl_off(LEVELS) +: ACC_W];

  if (OUT_W < ACC_W) begin : g_ovf_chk
    logic [ACC_W-OUT_W:0] hi;
    assign hi      = sum[ACC_W-1:OUT_W-1];
    assign out_ovf = ~((&hi) | ~(|hi));
  end else begin : g_ovf_none
    assign out_ovf = 1'b0;
  end

`ifdef LINCOMB_SAT_EN
  assign out_data = !out_ovf ? sum[OUT_W-1:0] :
                    sum[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
`else
  assign out_data = sum[OUT_W-1:0];
`endif

endmodule

`default_nettype wire

// File: tb/tb_lincomb_pipe.sv
// ============================================================================
// tb_lincomb_pipe : directed + randomized bench for lincomb_pipe against a queue model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_lincomb_pipe;
  import lincomb_pkg::*;

  localparam int N = 4;

  logic        clk, rst;
  logic        in_valid, in_ready;
  logic [31:0] in_data;
  logic        cfg_we;
  logic [2:0]  cfg_addr;
  logic [19:0] cfg_data;
  logic        out_valid, out_ready, out_ovf, busy;
  logic [15:0] out_data;

  int errors = 0;
  int checks = 0;

  longint mcoef [N];
  longint mbias;
  longint q [$];

  lincomb_pipe #(
    .N_TERMS (4), .IN_W (8), .COEF_W (5), .ACC_W (20), .OUT_W (16)
  ) dut (
    .clk (clk), .rst (rst),
    .in_valid (in_valid), .in_ready (in_ready), .in_data (in_data),
    .cfg_we (cfg_we), .cfg_addr (cfg_addr), .cfg_data (cfg_data),
    .out_valid (out_valid), .out_ready (out_ready),
    .out_data (out_data), .out_ovf (out_ovf), .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic longint model_sum(input logic [31:0] d);
    longint s;
    s = mbias;
    for (int i = 0; i < N; i++) s += longint'(d[i*8 +: 8]) * mcoef[i];
    return s;
  endfunction

  function automatic longint exp_data(input longint s);
    longint w;
`ifdef LINCOMB_SAT_EN
    w = (s > 32767) ? 32767 : (s < -32768) ? -32768 : s;
`else
    w = s & 64'hFFFF;
    if (w >= 32768) w -= 65536;
`endif
    return w;
  endfunction

  function automatic longint exp_ovf(input longint s);
    return (s > 32767 || s < -32768) ? 1 : 0;
  endfunction

  // Reference model and per-cycle compare
  always @(negedge clk) begin
    longint k;
    if (!rst) begin
      q.delete();
      for (int i = 0; i < N; i++) mcoef[i] = 0;
      mbias = 0;
      check("rst_out_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_out_data", out_data, 0);
    end else begin
      check("busy", busy, (q.size() > 0) ? 1 : 0);
      check("in_ready", in_ready, (!out_valid || out_ready) ? 1 : 0);
      if (out_valid) begin
        if (q.size() == 0) check("out_valid_no_sample", out_valid, 0);
        else begin
          check("out_data", longint'($signed(out_data)), exp_data(q[0]));
          check("out_ovf", out_ovf, exp_ovf(q[0]));
          if (out_ready) void'(q.pop_front());
        end
      end
      if (in_valid && in_ready) q.push_back(model_sum(in_data));
      if (cfg_we) begin
        if (cfg_addr < N) begin
          k = $signed(cfg_data[4:0]);
          mcoef[cfg_addr] = k;
        end else if (cfg_addr == BIAS_ADDR) begin
          k = $signed(cfg_data);
          mbias = k;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input int addr, input longint data);
    cfg_we = 1'b1; cfg_addr = addr[2:0]; cfg_data = data[19:0];
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic send(input logic [31:0] d);
    int n;
    bit acc;
    n = 0;
    in_valid = 1'b1; in_data = d;
    do begin
      @(negedge clk);
      acc = in_ready;
      tick();
      n++;
    end while (!acc && n < 200);
    in_valid = 1'b0;
    if (!acc) check("send_timeout", acc, 1);
  endtask

  task automatic wait_out(output longint d, output logic o);
    int n;
    n = 0;
    while (!(out_valid && out_ready) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("wait_out_in_time", (n < 200) ? 1 : 0, 1);
    d = $signed(out_data);
    o = out_ovf;
    tick();
  endtask

  task automatic run_case(input string nm, input int k, input longint b, input logic [7:0] x,
                          input longint e_wrap, input longint e_sat, input int e_ovf);
    longint d;
    logic   o;
    for (int i = 0; i < N; i++) cfg_write(i, k);
    cfg_write(BIAS_ADDR, b);
    send({4{x}});
    wait_out(d, o);
`ifdef LINCOMB_SAT_EN
    check(nm, d, e_sat);
`else
    check(nm, d, e_wrap);
`endif
    check({nm, "_ovf"}, o, e_ovf);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    longint d;
    logic   o;
    bit     saw_low;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; cfg_we = 1'b0; cfg_addr = '0;
    cfg_data = '0; out_ready = 1'b1;
    #2 rst = 1'b0;
    repeat (3) tick();
    check("reset_out_valid", out_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_out_data", out_data, 0);
    check("reset_out_ovf", out_ovf, 0);
    rst = 1'b1;
    tick();

    // Basic equation 5A+5B-4C+0D+2304, exact latency
    cfg_write(0, 5); cfg_write(1, 5); cfg_write(2, -4); cfg_write(3, 0);
    cfg_write(BIAS_ADDR, 2304);
    in_valid = 1'b1; in_data = {8'd0, 8'd5, 8'd20, 8'd10};
    check("basic_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    tick(); tick();
    check("basic_not_early", out_valid, 0);
    tick();
    check("basic_valid_lat4", out_valid, 1);
    check("basic_data", longint'($signed(out_data)), 2434);
    check("basic_ovf", out_ovf, 0);
    tick();

    // Back-to-back stream, k0=3
    cfg_write(0, 3); cfg_write(1, 0); cfg_write(2, 0); cfg_write(BIAS_ADDR, 0);
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          in_valid = 1'b1; in_data = 32'(i);
          @(negedge clk);
          check("stream_in_ready", in_ready, 1);
          tick();
        end
        in_valid = 1'b0;
      end
      begin
        repeat (4) tick();
        for (int i = 0; i < 8; i++) begin
          check("stream_valid", out_valid, 1);
          check("stream_data", longint'($signed(out_data)), 3 * i);
          tick();
        end
      end
    join

    // Mid-stream stall
    cfg_write(1, -7); cfg_write(2, 11); cfg_write(3, -16); cfg_write(BIAS_ADDR, -500);
    saw_low = 1'b0;
    fork
      for (int i = 0; i < 16; i++) send($urandom);
      begin
        repeat (5) tick();
        out_ready = 1'b0;
        repeat (6) begin
          @(negedge clk);
          if (!in_ready) saw_low = 1'b1;
          tick();
        end
        out_ready = 1'b1;
      end
    join
    check("stall_in_ready_dropped", saw_low, 1);
    repeat (8) tick();
    check("stall_drained", q.size(), 0);

    // Config write in the same cycle as acceptance
    cfg_write(0, 2); cfg_write(1, 0); cfg_write(2, 0); cfg_write(3, 0); cfg_write(BIAS_ADDR, 0);
    in_valid = 1'b1; in_data = 32'd100;
    cfg_we = 1'b1; cfg_addr = 3'd0; cfg_data = 20'hFFFFF;
    tick();
    cfg_we = 1'b0;
    tick();
    in_valid = 1'b0;
    wait_out(d, o);
    check("samecyc_old_coef", d, 200);
    wait_out(d, o);
    check("samecyc_new_coef", d, -100);

    // Overflow and range boundaries
    run_case("ovf_pos",    15,  20000, 8'd255, -30236,  32767, 1);
    run_case("ovf_neg",   -16, -20000, 8'd255,  29216, -32768, 1);
    run_case("edge_max",    0,  32767, 8'd77,   32767,  32767, 0);
    run_case("edge_max1",   0,  32768, 8'd77,  -32768,  32767, 1);
    run_case("edge_min",    0, -32768, 8'd77,  -32768, -32768, 0);
    run_case("edge_min1",   0, -32769, 8'd77,   32767, -32768, 1);

    // Reset with samples in flight
    cfg_write(0, 1); cfg_write(BIAS_ADDR, 9);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 32'(i + 1);
      tick();
    end
    in_valid = 1'b0;
    check("pre_rst_busy", busy, 1);
    #1 rst = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_out_data", out_data, 0);
    repeat (2) tick();
    rst = 1'b1;
    repeat (6) begin
      tick();
      check("post_rst_no_stale", out_valid, 0);
    end
    send({4{8'd200}});
    wait_out(d, o);
    check("post_rst_zero_coefs", d, 0);

    // Randomized traffic with config writes, including ignored addresses
    for (int c = 0; c < 800; c++) begin
      in_valid  = $urandom_range(0, 1);
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      cfg_we    = ($urandom_range(0, 7) == 0);
      cfg_addr  = 3'($urandom_range(0, 7));
      cfg_data  = 20'($urandom);
      if (cfg_addr == 3'(BIAS_ADDR)) begin
        if ($urandom_range(0, 1) != 0) cfg_data = 20'($signed($urandom_range(0, 65535)) - 32768);
        else                           cfg_data = 20'($signed($urandom_range(0, 262143)) - 131072);
      end
      tick();
    end
    in_valid = 1'b0; cfg_we = 1'b0; out_ready = 1'b1;
    repeat (10) tick();
    check("random_drained", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
